// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state encoding, opcode/funct fields, aluop classes and ALU control codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the controller's aluop class and the instruction funct
// field onto the 3-bit operation code consumed by the ALU.
module aludec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALUCTL_ADD;
        case (i_aluop)
            ALUOP_SUB: o_alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct codes fall back to add so R-type writeback stays harmless
                case (i_funct)
                    FUNCT_ADD: o_alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: o_alucontrol = ALUCTL_SUB;
                    FUNCT_AND: o_alucontrol = ALUCTL_AND;
                    FUNCT_OR:  o_alucontrol = ALUCTL_OR;
                    FUNCT_SLT: o_alucontrol = ALUCTL_SLT;
                    default:   o_alucontrol = ALUCTL_ADD;
                endcase
            end
            default: o_alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute states and
// drives datapath selects, write strobes and the ALU operation code.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    statetype   r_state;
    statetype   w_next_state;
    statetype   w_dec_state;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= statetype'(RESET_STATE);
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH: w_next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:   w_next_state = MEMADR;
                    OP_RTYPE:       w_next_state = EXECUTE;
                    OP_BEQ, OP_BNE: w_next_state = BRANCH;
                    OP_ADDI:        w_next_state = ADDIEX;
                    OP_J:           w_next_state = JUMP;
                    default:        w_next_state = FETCH;
                endcase
            end
            MEMADR:  w_next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next_state = MEMWB;
            EXECUTE: w_next_state = ALUWB;
            ADDIEX:  w_next_state = ADDIWB;
            default: w_next_state = FETCH;
        endcase
    end

    // While reset is held, present FETCH-style selects regardless of the stored state
    assign w_dec_state = reset_n ? r_state : FETCH;

    always_comb begin
        iord       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = ALUOP_ADD;
        case (w_dec_state)
            FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            ADDIWB: w_regwrite = 1'b1;
            JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // op[0] distinguishes bne from beq, flipping the sense of the zero flag
    assign memwrite = w_memwrite & reset_n;
    assign irwrite  = w_irwrite & reset_n;
    assign regwrite = w_regwrite & reset_n;
    assign pcen     = reset_n & (w_pcwrite | (w_branch & (zero ^ op[0])));
    assign state    = r_state;

    aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a per-instruction behavioural model
// predicts state sequence and outputs, checked every cycle on the falling edge.
module tb_mc_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_pass;
    int n_checks;

    logic [3:0] exp_state;
    logic       exp_rst;
    logic       exp_valid;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluc;
    } outs_t;

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    endtask

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // What each state must present, written from the state/output table
    function automatic outs_t model(input logic [3:0] st, input logic rst,
                                    input logic [5:0] o, input logic [5:0] f, input logic z);
        outs_t e;
        e = '0;
        e.aluc = 3'b010;
        if (rst) begin
            e.alusrcb = 2'b01;
            return e;
        end
        case (st)
            4'd0:  begin e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1; end
            4'd1:  e.alusrcb = 2'b11;
            4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd3:  e.iord = 1'b1;
            4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            4'd6:  begin e.alusrca = 1'b1; e.aluc = rtype_alu(f); end
            4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            4'd8:  begin
                e.alusrca = 1'b1;
                e.pcsrc   = 2'b01;
                e.aluc    = 3'b110;
                e.pcen    = (o == 6'b000100) ? z : !z;
            end
            4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd10: e.regwrite = 1'b1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            outs_t e;
            e = model(exp_state, exp_rst, op, funct, zero);
            chk("state",      state,             exp_state);
            chk("iord",       {3'b0, iord},      {3'b0, e.iord});
            chk("memwrite",   {3'b0, memwrite},  {3'b0, e.memwrite});
            chk("irwrite",    {3'b0, irwrite},   {3'b0, e.irwrite});
            chk("regwrite",   {3'b0, regwrite},  {3'b0, e.regwrite});
            chk("regdst",     {3'b0, regdst},    {3'b0, e.regdst});
            chk("memtoreg",   {3'b0, memtoreg},  {3'b0, e.memtoreg});
            chk("alusrca",    {3'b0, alusrca},   {3'b0, e.alusrca});
            chk("alusrcb",    {2'b0, alusrcb},   {2'b0, e.alusrcb});
            chk("pcsrc",      {2'b0, pcsrc},     {2'b0, e.pcsrc});
            chk("pcen",       {3'b0, pcen},      {3'b0, e.pcen});
            chk("alucontrol", {1'b0, alucontrol}, {1'b0, e.aluc});
        end
    end

    // Runs one instruction (or its first nmax cycles); in state 'key' also
    // checks hand-computed alucontrol/pcen literals.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int key, input logic [2:0] lit_alu, input logic lit_pcen,
                             input int nmax);
        int s[6];
        int n;
        case (o)
            6'b100011: begin s = '{0, 1, 2, 3, 4, 0}; n = 5; end
            6'b101011: begin s = '{0, 1, 2, 5, 0, 0}; n = 4; end
            6'b000000: begin s = '{0, 1, 6, 7, 0, 0}; n = 4; end
            6'b000100, 6'b000101: begin s = '{0, 1, 8, 0, 0, 0}; n = 3; end
            6'b001000: begin s = '{0, 1, 9, 10, 0, 0}; n = 4; end
            6'b000010: begin s = '{0, 1, 11, 0, 0, 0}; n = 3; end
            default:   begin s = '{0, 1, 0, 0, 0, 0}; n = 2; end
        endcase
        if (nmax < n) n = nmax;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                reset_n = 1'b1;
                exp_rst = 1'b0;
                op      = o;
                funct   = f;
                zero    = z;
            end
            exp_state = 4'(s[i]);
            exp_valid = 1'b1;
            if (s[i] == key) begin
                @(negedge clk);
                chk("lit_alucontrol", {1'b0, alucontrol}, {1'b0, lit_alu});
                chk("lit_pcen", {3'b0, pcen}, {3'b0, lit_pcen});
            end
        end
        $display("instr op=%b funct=%b zero=%b cycles=%0d", o, f, z, n);
    endtask

    // Drops reset in the middle of the current cycle and keeps it low for k edges;
    // the following run_instr releases it after the k-th edge.
    task automatic reset_hold(input int k);
        #1;
        reset_n = 1'b0;
        exp_rst = 1'b1;
        @(negedge clk);
        chk("rst_regwrite", {3'b0, regwrite}, 4'd0);
        chk("rst_pcen", {3'b0, pcen}, 4'd0);
        for (int j = 1; j < k; j++) begin
            @(posedge clk);
            #1;
            exp_state = 4'd0;
            @(negedge clk);
            chk("rst_state", state, 4'd0);
            chk("rst_irwrite", {3'b0, irwrite}, 4'd0);
            chk("rst_memwrite", {3'b0, memwrite}, 4'd0);
        end
        $display("reset held for %0d edges", k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass    = 0;
        n_checks  = 0;
        exp_valid = 1'b0;
        exp_rst   = 1'b1;
        exp_state = 4'd0;
        reset_n   = 1'b0;
        op        = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_valid = 1'b1;
        @(negedge clk);
        chk("init_state", state, 4'd0);

        run_instr(6'b100011, 6'd0, 1'b0, 0, 3'b010, 1'b1, 9);
        run_instr(6'b000000, 6'b100000, 1'b0, 6, 3'b010, 1'b0, 9);
        run_instr(6'b000000, 6'b100010, 1'b0, 6, 3'b110, 1'b0, 9);
        run_instr(6'b000000, 6'b100100, 1'b0, 6, 3'b000, 1'b0, 9);
        run_instr(6'b000000, 6'b100101, 1'b0, 6, 3'b001, 1'b0, 9);
        run_instr(6'b000000, 6'b101010, 1'b0, 6, 3'b111, 1'b0, 9);
        run_instr(6'b000000, 6'b111111, 1'b0, 6, 3'b010, 1'b0, 9);
        run_instr(6'b000100, 6'd0, 1'b1, 8, 3'b110, 1'b1, 9);
        run_instr(6'b000100, 6'd0, 1'b0, 8, 3'b110, 1'b0, 9);
        run_instr(6'b000101, 6'd0, 1'b0, 8, 3'b110, 1'b1, 9);
        run_instr(6'b000101, 6'd0, 1'b1, 8, 3'b110, 1'b0, 9);
        run_instr(6'b101011, 6'd0, 1'b0, 5, 3'b010, 1'b0, 9);
        run_instr(6'b000010, 6'd0, 1'b0, 11, 3'b010, 1'b1, 9);
        run_instr(6'b001000, 6'd0, 1'b0, 9, 3'b010, 1'b0, 9);
        run_instr(6'b111111, 6'd0, 1'b1, 1, 3'b010, 1'b0, 9);
        run_instr(6'b000000, 6'b100010, 1'b0, 7, 3'b010, 1'b0, 9);

        // R-type abandoned in EXECUTE by a two-edge reset
        run_instr(6'b000000, 6'b100010, 1'b0, -1, 3'b010, 1'b0, 3);
        reset_hold(2);
        run_instr(6'b100011, 6'd0, 1'b0, 0, 3'b010, 1'b1, 9);
        run_instr(6'b001000, 6'd0, 1'b0, 10, 3'b010, 1'b0, 9);

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
